// File: rtl/ledger_engine.sv
// -----------------------------------------------------------------------------
// ledger_engine
//
// Purpose:
//    Small transaction engine over an external record store. Each account
//    record is {key, balance}. The engine can initialise every record, or run
//    one transaction (transfer, deposit, withdraw). Before it writes anything
//    back, it checks the presented key, the available funds and balance
//    overflow. Committed transactions are counted.
//
// Ports:
//    clock      in   rising-edge clock
//    reset      in   synchronous, active-high reset
//    init       in   pulse: write the initial record to every account
//    start      in   pulse: run one transaction described by mode/ids/amount/key
//    mode       in   00 transfer, 01 deposit, 10 withdraw, 11 illegal
//    src_id     in   source account
//    dst_id     in   destination account
//    amount     in   transaction amount
//    key        in   presented key
//    mem_req    out  memory request, held until mem_ack
//    mem_we     out  1 = write, 0 = read
//    mem_addr   out  record address
//    mem_wdata  out  record to write
//    mem_rdata  in   record read, valid in the mem_ack cycle
//    mem_ack    in   request accepted / completed
//    busy       out  engine not idle
//    done       out  one-cycle completion pulse
//    error      out  0 ok, 1 bad key, 2 insufficient, 3 overflow,
//                    4 same id, 5 illegal mode
//    tx_count   out  committed transaction count (wraps)
// -----------------------------------------------------------------------------
module ledger_engine #(
   parameter int               NUM_PLAYERS = 4,
   parameter int               BAL_W       = 8,
   parameter int               KEY_W       = 8,
   parameter int               CNT_W       = 8,
   parameter int               INIT_BAL    = 100,
   parameter logic [KEY_W-1:0] INIT_KEY    = 8'hA5,
   localparam int              ID_W        = $clog2(NUM_PLAYERS),
   localparam int              REC_W       = KEY_W + BAL_W
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             init,
   input  logic             start,
   input  logic [1:0]       mode,
   input  logic [ID_W-1:0]  src_id,
   input  logic [ID_W-1:0]  dst_id,
   input  logic [BAL_W-1:0] amount,
   input  logic [KEY_W-1:0] key,
   output logic             mem_req,
   output logic             mem_we,
   output logic [ID_W-1:0]  mem_addr,
   output logic [REC_W-1:0] mem_wdata,
   input  logic [REC_W-1:0] mem_rdata,
   input  logic             mem_ack,
   output logic             busy,
   output logic             done,
   output logic [2:0]       error,
   output logic [CNT_W-1:0] tx_count
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_INIT,
      S_RD_SRC,
      S_RD_DST,
      S_CHECK,
      S_WR_SRC,
      S_WR_DST,
      S_FIN
   } state_e;

   typedef enum logic [1:0] {
      MODE_XFER = 2'b00,
      MODE_DEP  = 2'b01,
      MODE_WDR  = 2'b10,
      MODE_ILL  = 2'b11
   } mode_e;

   typedef enum logic [2:0] {
      ERR_OK    = 3'd0,
      ERR_KEY   = 3'd1,
      ERR_FUNDS = 3'd2,
      ERR_OVF   = 3'd3,
      ERR_SAME  = 3'd4,
      ERR_MODE  = 3'd5
   } err_e;

   localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_PLAYERS - 1);

   // Initial record for one account: the base key is personalised by the id.
   function automatic logic [REC_W-1:0] init_rec(input logic [ID_W-1:0] id);
      return {INIT_KEY ^ KEY_W'(id), BAL_W'(INIT_BAL)};
   endfunction

   // ---------------------------------------------------------------------------
   // State and registered outputs
   // ---------------------------------------------------------------------------
   state_e             state_q,     state_d;
   mode_e              mode_q,      mode_d;
   logic [ID_W-1:0]    src_q,       src_d;
   logic [ID_W-1:0]    dst_q,       dst_d;
   logic [BAL_W-1:0]   amt_q,       amt_d;
   logic [KEY_W-1:0]   key_q,       key_d;
   logic [REC_W-1:0]   src_rec_q,   src_rec_d;
   logic [REC_W-1:0]   dst_rec_q,   dst_rec_d;
   logic [ID_W-1:0]    idx_q,       idx_d;
   logic               mem_req_q,   mem_req_d;
   logic               mem_we_q,    mem_we_d;
   logic [ID_W-1:0]    mem_addr_q,  mem_addr_d;
   logic [REC_W-1:0]   mem_wdata_q, mem_wdata_d;
   logic               busy_q,      busy_d;
   logic               done_q,      done_d;
   err_e               error_q,     error_d;
   logic [CNT_W-1:0]   tx_count_q,  tx_count_d;

   // ---------------------------------------------------------------------------
   // CHECK-stage evaluation of the captured records
   // ---------------------------------------------------------------------------
   logic [KEY_W-1:0] src_key, dst_key;
   logic [BAL_W-1:0] src_bal, dst_bal;
   logic [BAL_W:0]   dst_sum;        // one extra bit exposes overflow
   logic             uses_src, uses_dst;
   logic [REC_W-1:0] src_new, dst_new;
   err_e             check_err;

   assign src_key  = src_rec_q[REC_W-1 -: KEY_W];
   assign src_bal  = src_rec_q[BAL_W-1:0];
   assign dst_key  = dst_rec_q[REC_W-1 -: KEY_W];
   assign dst_bal  = dst_rec_q[BAL_W-1:0];
   assign dst_sum  = {1'b0, dst_bal} + {1'b0, amt_q};
   assign uses_src = (mode_q != MODE_DEP);
   assign uses_dst = (mode_q != MODE_WDR);
   assign src_new  = {src_key, src_bal - amt_q};
   assign dst_new  = {dst_key, dst_sum[BAL_W-1:0]};

   // First failing rule wins: key, then funds, then overflow.
   always_comb begin
      check_err = ERR_OK;
      if ((mode_q == MODE_DEP) ? (dst_key != key_q) : (src_key != key_q)) begin
         check_err = ERR_KEY;
      end else if (uses_src && (src_bal < amt_q)) begin
         check_err = ERR_FUNDS;
      end else if (uses_dst && dst_sum[BAL_W]) begin
         check_err = ERR_OVF;
      end
   end

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      // NOTE: every *_d starts from its current value so that no path through
      // the case statement leaves a variable unassigned (which would infer a latch).
      state_d     = state_q;
      mode_d      = mode_q;
      src_d       = src_q;
      dst_d       = dst_q;
      amt_d       = amt_q;
      key_d       = key_q;
      src_rec_d   = src_rec_q;
      dst_rec_d   = dst_rec_q;
      idx_d       = idx_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      done_d      = 1'b0;
      error_d     = error_q;
      tx_count_d  = tx_count_q;

      unique case (state_q)
         S_IDLE: begin
            mem_req_d = 1'b0;
            mem_we_d  = 1'b0;
            if (init) begin
               // init wins over a simultaneous start
               error_d     = ERR_OK;
               idx_d       = '0;
               state_d     = S_INIT;
               mem_req_d   = 1'b1;
               mem_we_d    = 1'b1;
               mem_addr_d  = '0;
               mem_wdata_d = init_rec('0);
            end else if (start) begin
               mode_d  = mode_e'(mode);
               src_d   = src_id;
               dst_d   = dst_id;
               amt_d   = amount;
               key_d   = key;
               error_d = ERR_OK;
               if (mode_e'(mode) == MODE_ILL) begin
                  state_d = S_FIN;
                  error_d = ERR_MODE;
                  done_d  = 1'b1;
               end else if ((mode_e'(mode) == MODE_XFER) && (src_id == dst_id)) begin
                  state_d = S_FIN;
                  error_d = ERR_SAME;
                  done_d  = 1'b1;
               end else if (mode_e'(mode) == MODE_DEP) begin
                  state_d    = S_RD_DST;
                  mem_req_d  = 1'b1;
                  mem_addr_d = dst_id;
               end else begin
                  state_d    = S_RD_SRC;
                  mem_req_d  = 1'b1;
                  mem_addr_d = src_id;
               end
            end
         end

         S_INIT: begin
            if (mem_ack) begin
               if (idx_q == LAST_ID) begin
                  state_d   = S_FIN;
                  mem_req_d = 1'b0;
                  mem_we_d  = 1'b0;
                  error_d   = ERR_OK;
                  done_d    = 1'b1;
               end else begin
                  idx_d       = idx_q + ID_W'(1);
                  mem_addr_d  = idx_q + ID_W'(1);
                  mem_wdata_d = init_rec(idx_q + ID_W'(1));
               end
            end
         end

         S_RD_SRC: begin
            if (mem_ack) begin
               src_rec_d = mem_rdata;
               if (mode_q == MODE_XFER) begin
                  state_d    = S_RD_DST;
                  mem_addr_d = dst_q;
               end else begin
                  state_d   = S_CHECK;
                  mem_req_d = 1'b0;
               end
            end
         end

         S_RD_DST: begin
            if (mem_ack) begin
               dst_rec_d = mem_rdata;
               state_d   = S_CHECK;
               mem_req_d = 1'b0;
            end
         end

         S_CHECK: begin
            if (check_err != ERR_OK) begin
               state_d = S_FIN;
               error_d = check_err;
               done_d  = 1'b1;
            end else if (mode_q == MODE_DEP) begin
               state_d     = S_WR_DST;
               mem_req_d   = 1'b1;
               mem_we_d    = 1'b1;
               mem_addr_d  = dst_q;
               mem_wdata_d = dst_new;
            end else begin
               state_d     = S_WR_SRC;
               mem_req_d   = 1'b1;
               mem_we_d    = 1'b1;
               mem_addr_d  = src_q;
               mem_wdata_d = src_new;
            end
         end

         S_WR_SRC: begin
            if (mem_ack) begin
               if (mode_q == MODE_XFER) begin
                  // transfer debits the source before crediting the destination
                  state_d     = S_WR_DST;
                  mem_addr_d  = dst_q;
                  mem_wdata_d = dst_new;
               end else begin
                  state_d    = S_FIN;
                  mem_req_d  = 1'b0;
                  mem_we_d   = 1'b0;
                  done_d     = 1'b1;
                  tx_count_d = tx_count_q + CNT_W'(1);
               end
            end
         end

         S_WR_DST: begin
            if (mem_ack) begin
               state_d    = S_FIN;
               mem_req_d  = 1'b0;
               mem_we_d   = 1'b0;
               done_d     = 1'b1;
               tx_count_d = tx_count_q + CNT_W'(1);
            end
         end

         S_FIN: begin
            // done was raised on entry; error stays until the next acceptance
            state_d = S_IDLE;
         end

         default: begin
            state_d   = S_IDLE;
            mem_req_d = 1'b0;
            mem_we_d  = 1'b0;
         end
      endcase

      busy_d = (state_d != S_IDLE);
   end

   // ---------------------------------------------------------------------------
   // Registers (synchronous reset clears everything, abandoning any access)
   // ---------------------------------------------------------------------------
   always_ff @(posedge clock) begin
      // NOTE: non-blocking assignments here so every flop samples the values
      // computed for this edge, independent of statement order.
      if (reset) begin
         state_q     <= S_IDLE;
         mode_q      <= MODE_XFER;
         src_q       <= '0;
         dst_q       <= '0;
         amt_q       <= '0;
         key_q       <= '0;
         src_rec_q   <= '0;
         dst_rec_q   <= '0;
         idx_q       <= '0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         error_q     <= ERR_OK;
         tx_count_q  <= '0;
      end else begin
         state_q     <= state_d;
         mode_q      <= mode_d;
         src_q       <= src_d;
         dst_q       <= dst_d;
         amt_q       <= amt_d;
         key_q       <= key_d;
         src_rec_q   <= src_rec_d;
         dst_rec_q   <= dst_rec_d;
         idx_q       <= idx_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         error_q     <= error_d;
         tx_count_q  <= tx_count_d;
      end
   end

   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign error     = error_q;
   assign tx_count  = tx_count_q;

endmodule

// File: tb/tb_ledger_engine.sv
// -----------------------------------------------------------------------------
// tb_ledger_engine
//
// Drives ledger_engine (4 accounts, 8-bit balances/keys, 2-bit commit counter
// so wrap-around is reached) against a behavioural record store with a
// programmable ack delay. Expected errors, write sequences, latencies and
// commit counts come from an account-level reference model.
// -----------------------------------------------------------------------------
module tb_ledger_engine;

   localparam int CNT_W = 2;

   logic        clock = 1'b0;
   logic        reset;
   logic        init, start;
   logic [1:0]  mode, src_id, dst_id;
   logic [7:0]  amount, key;
   logic        mem_req, mem_we, mem_ack;
   logic [1:0]  mem_addr;
   logic [15:0] mem_wdata, mem_rdata;
   logic        busy, done;
   logic [2:0]  error;
   logic [CNT_W-1:0] tx_count;

   ledger_engine #(
      .NUM_PLAYERS (4),
      .BAL_W       (8),
      .KEY_W       (8),
      .CNT_W       (CNT_W),
      .INIT_BAL    (100),
      .INIT_KEY    (8'hA5)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .init      (init),
      .start     (start),
      .mode      (mode),
      .src_id    (src_id),
      .dst_id    (dst_id),
      .amount    (amount),
      .key       (key),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_ack   (mem_ack),
      .busy      (busy),
      .done      (done),
      .error     (error),
      .tx_count  (tx_count)
   );

   always #5 clock = ~clock;

   // ---------------------------------------------------------------------------
   // Record store: ack after ack_delay waiting cycles (0 = ack tied high)
   // ---------------------------------------------------------------------------
   logic [15:0] mem [4];
   logic [17:0] wr_log [$];     // {addr, record} of every accepted write
   int          ack_delay = 0;
   int          wait_cnt  = 0;

   assign mem_rdata = mem[mem_addr];
   assign mem_ack   = (ack_delay == 0) ? 1'b1 : (mem_req && (wait_cnt == ack_delay));

   always @(posedge clock) begin
      if (mem_req && !mem_ack) wait_cnt <= wait_cnt + 1;
      else                     wait_cnt <= 0;
      if (mem_req && mem_ack && mem_we) begin
         mem[mem_addr] <= mem_wdata;
         wr_log.push_back({mem_addr, mem_wdata});
      end
   end

   // ---------------------------------------------------------------------------
   // Checking
   // ---------------------------------------------------------------------------
   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Request signals must not move while waiting for ack.
   logic [19:0] prev_req     = '0;
   logic        prev_pending = 1'b0;
   logic        rst_edge     = 1'b0;

   always @(posedge clock) rst_edge <= reset;

   always @(negedge clock) begin
      if (prev_pending && !rst_edge)
         check("req_hold", {mem_req, mem_we, mem_addr, mem_wdata}, prev_req);
      prev_pending <= mem_req && !mem_ack;
      prev_req     <= {mem_req, mem_we, mem_addr, mem_wdata};
   end

   // ---------------------------------------------------------------------------
   // Reference model state
   // ---------------------------------------------------------------------------
   logic [15:0] ref_mem [4];
   int          ref_tx = 0;

   // Run one operation from IDLE (called at a negedge). poke re-asserts
   // start/init with junk fields while the engine is busy.
   task automatic run_op(input bit do_init, input bit do_start, input logic [1:0] m,
                         input logic [1:0] s, input logic [1:0] d,
                         input logic [7:0] a, input logic [7:0] k, input bit poke);
      logic [17:0] exp_wr [$];
      int          exp_err, exp_lat, nrd, nwr, lat;
      bit          use_src, use_dst, got_done;
      logic [7:0]  sk, sb, dk, db;

      exp_err = 0;
      if (do_init) begin
         for (int i = 0; i < 4; i++) begin
            ref_mem[i] = {8'hA5 ^ 8'(i), 8'd100};
            exp_wr.push_back({2'(i), ref_mem[i]});
         end
         exp_lat = 1 + 4 * (1 + ack_delay);
      end else if (m == 2'b11) begin
         exp_err = 5;
         exp_lat = 1;
      end else if (m == 2'b00 && s == d) begin
         exp_err = 4;
         exp_lat = 1;
      end else begin
         {sk, sb} = ref_mem[s];
         {dk, db} = ref_mem[d];
         use_src  = (m != 2'b01);
         use_dst  = (m != 2'b10);
         nrd      = int'(use_src) + int'(use_dst);
         if (k != ((m == 2'b01) ? dk : sk))                 exp_err = 1;
         else if (use_src && (int'(sb) < int'(a)))           exp_err = 2;
         else if (use_dst && (int'(db) + int'(a) > 255))     exp_err = 3;
         exp_lat = 1 + nrd * (1 + ack_delay) + 1;
         if (exp_err == 0) begin
            nwr = 0;
            if (use_src) begin
               ref_mem[s] = {sk, 8'(int'(sb) - int'(a))};
               exp_wr.push_back({s, ref_mem[s]});
               nwr++;
            end
            if (use_dst) begin
               ref_mem[d] = {dk, 8'(int'(db) + int'(a))};
               exp_wr.push_back({d, ref_mem[d]});
               nwr++;
            end
            exp_lat += nwr * (1 + ack_delay);
            ref_tx = (ref_tx + 1) % (1 << CNT_W);
         end
      end

      wr_log.delete();
      init = do_init; start = do_start;
      mode = m; src_id = s; dst_id = d; amount = a; key = k;
      lat = 0;
      got_done = 1'b0;
      while (lat < 200 && !got_done) begin
         @(posedge clock);
         lat++;
         @(negedge clock);
         init  = 1'b0;
         start = 1'b0;
         if (poke && exp_lat >= 3 && lat == 2) begin
            init   = 1'($urandom);
            start  = 1'b1;
            mode   = 2'($urandom);
            src_id = 2'($urandom);
            dst_id = 2'($urandom);
            amount = 8'($urandom);
            key    = 8'($urandom);
         end
         got_done = done;
      end

      check("latency", lat, exp_lat);
      check("error", error, exp_err);
      check("wr_count", wr_log.size(), exp_wr.size());
      for (int i = 0; i < exp_wr.size() && i < wr_log.size(); i++)
         check("wr_rec", wr_log[i], exp_wr[i]);

      @(posedge clock);
      @(negedge clock);
      check("done_pulse", done, 0);
      check("error_hold", error, exp_err);
      check("busy_idle", busy, 0);
      check("tx_count", tx_count, ref_tx);
   endtask

   // ---------------------------------------------------------------------------
   // Stimulus
   // ---------------------------------------------------------------------------
   initial begin
      logic [1:0] m, s, d;
      logic [7:0] a, k;
      int         r, tx_before;

      reset = 1'b1; init = 1'b0; start = 1'b0;
      mode = '0; src_id = '0; dst_id = '0; amount = '0; key = '0;
      repeat (3) @(posedge clock);
      @(negedge clock);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_error", error, 0);
      check("rst_tx", tx_count, 0);
      check("rst_req", mem_req, 0);
      check("rst_we", mem_we, 0);
      reset = 1'b0;

      // Initialisation and the documented scenarios
      run_op(1, 0, 2'b00, 0, 0, 8'd0, 8'h00, 0);
      check("init_rec3", mem[3], 16'hA664);
      run_op(0, 1, 2'b00, 0, 1, 8'd30, 8'hA5, 0);           // transfer -> 70 / 130
      check("xfer_rec0", mem[0], {8'hA5, 8'd70});
      check("xfer_rec1", mem[1], {8'hA4, 8'd130});
      run_op(0, 1, 2'b10, 2, 0, 8'd101, 8'hA7, 0);          // insufficient
      run_op(0, 1, 2'b00, 1, 1, 8'd5, 8'hA4, 0);            // same id
      run_op(0, 1, 2'b01, 0, 1, 8'd120, 8'hA4, 0);          // dst1 -> 250
      run_op(0, 1, 2'b01, 0, 1, 8'd10, 8'hA4, 0);           // overflow
      run_op(0, 1, 2'b01, 0, 3, 8'd5, 8'h00, 0);            // bad key
      run_op(0, 1, 2'b11, 0, 1, 8'd5, 8'hA5, 0);            // illegal mode
      ack_delay = 3;
      run_op(0, 1, 2'b00, 0, 2, 8'd10, 8'hA5, 1);           // slow memory, busy poke
      ack_delay = 0;

      // Four zero-amount commits bring a 2-bit counter back to its start value
      tx_before = int'(tx_count);
      for (int i = 0; i < 4; i++) run_op(0, 1, 2'b10, 3, 0, 8'd0, 8'hA6, 0);
      check("tx_wrap", tx_count, tx_before);

      // init and start together: init wins
      run_op(1, 1, 2'b00, 0, 1, 8'd50, 8'hA5, 0);

      // Reset while the destination write of a transfer is pending
      ack_delay = 2;
      wr_log.delete();
      start = 1'b1; mode = 2'b00; src_id = 0; dst_id = 1; amount = 8'd1; key = 8'hA5;
      for (int i = 0; i < 60 && wr_log.size() < 1; i++) begin
         @(posedge clock);
         @(negedge clock);
         start = 1'b0;
      end
      check("rst_mid_src_wr", wr_log.size(), 1);
      reset = 1'b1;
      @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
      check("rst_mid_req", mem_req, 0);
      check("rst_mid_busy", busy, 0);
      check("rst_mid_tx", tx_count, 0);
      check("rst_mid_error", error, 0);
      repeat (3) @(negedge clock);
      check("rst_mid_no_dst_wr", wr_log.size(), 1);
      ref_mem[0] = {8'hA5, 8'd99};
      ref_tx     = 0;
      ack_delay  = 0;
      run_op(0, 1, 2'b00, 1, 0, 8'd5, 8'hA4, 0);            // accepted normally

      // Randomised traffic
      for (int n = 0; n < 150; n++) begin
         ack_delay = $urandom_range(0, 2);
         r = $urandom_range(0, 9);
         m = (r < 3) ? 2'b00 : (r < 6) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
         s = 2'($urandom);
         d = 2'($urandom);
         a = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 40));
         if ($urandom_range(0, 99) < 85) k = (m == 2'b01) ? ref_mem[d][15:8] : ref_mem[s][15:8];
         else                            k = 8'($urandom);
         if ($urandom_range(0, 99) < 4) run_op(1, 1'($urandom), m, s, d, a, k, 1'($urandom));
         else                           run_op(0, 1, m, s, d, a, k, $urandom_range(0, 4) == 0);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
